xidx_stack_sequencer: RTL and testbench
=======================================

Name: xidx_stack_sequencer

Overview:
- Parametrised sequencer for the index-register stack/transfer opcode group: POP xx, PUSH xx, EX (SP),xx, JP (xx), LD SP,xx.
- Generalises the IX/IY-only path to NUM_IDX index registers.
- Owns the SP register and the index register file, and runs a wait-state-tolerant byte-wide memory handshake.
- Sits between the prefix/opcode decoder (issues start/op/sel) and the external memory bus.

Parameters:
NUM_IDX, 2, number of index registers (IX=0, IY=1, ...); must be >=1
SEL_W, 2, width of register select; must satisfy 2^SEL_W >= NUM_IDX
ADDR_W, 16, address and SP width
DATA_W, 8, memory byte width; index registers are 2*DATA_W wide

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  request strobe; accepted only when busy=0
op  in  3  0=POP, 1=PUSH, 2=EX_SP, 3=JP, 4=LD_SP, 5..7 illegal
sel  in  SEL_W  index register select
busy  out  1  high from the cycle after acceptance until the done cycle inclusive
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse on an illegal op or sel>=NUM_IDX
mem_addr  out  ADDR_W  access address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, sampled when mem_ack=1
mem_rd  out  1  read request, held until ack
mem_wr  out  1  write request, held until ack
mem_ack  in  1  access completes on a rising edge where it is high
pc_load  out  1  one-cycle pulse: load PC from pc_val
pc_val  out  2*DATA_W  PC value for JP
cfg_we  in  1  direct register write; ignored while busy
cfg_sp  in  1  1: cfg_we targets SP, 0: targets idx[cfg_sel]
cfg_sel  in  SEL_W  direct-write register select
cfg_data  in  2*DATA_W  direct-write data
sp  out  ADDR_W  current SP
rd_sel  in  SEL_W  read-port select
rd_data  out  2*DATA_W  idx[rd_sel]; 0 if rd_sel>=NUM_IDX

Behaviour:
- Reset values: sp=all-ones, all idx=0, busy/done/err/mem_rd/mem_wr/pc_load=0, mem_addr=0, mem_wdata=0, pc_val=0, FSM=IDLE. Reset mid-operation aborts at the next edge: no register commit, requests drop.
- FSM states: IDLE, ACC (step 0..3), FIN.
- IDLE:
  - start with a legal op/sel: latch op/sel. Memory ops go to ACC step 0; JP/LD_SP go to FIN.
  - start with an illegal op or sel: err=1 for the next cycle, stay IDLE, no state change.
- ACC: exactly one of mem_rd/mem_wr is high, with mem_addr/mem_wdata held stable until the ack edge. On ack, advance the step. After the last step, go to FIN.
- POP:
  - Read low byte at SP, then SP+1; read high byte at SP, then SP+1.
  - SP updates at each ack edge.
- PUSH:
  - Write high byte at SP-1, then low byte at SP-2.
  - SP decrements at each ack edge; final SP = SP0-2.
- EX_SP:
  - Read [SP]=L', read [SP+1]=H', write [SP+1]=old high, write [SP]=old low.
  - SP unchanged. idx keeps its old value until FIN.
- FIN: done=1 and busy=1. Write commit is visible on rd_data/sp in the same cycle:
  - POP/EX: idx[sel]={H',L'}.
  - LD_SP: sp=idx[sel][ADDR_W-1:0].
  - JP: pc_load=1, pc_val=idx[sel].
  - Next cycle: IDLE.
- Latency from the start cycle with zero-wait ack to the done cycle: JP/LD_SP 1, POP/PUSH 3, EX_SP 5. Each wait cycle adds 1.
- SP arithmetic wraps modulo 2^ADDR_W (0000-1=FFFF, FFFF+1=0000).
- start while busy is ignored, with no err. A start in the done cycle is ignored; a new op is accepted from the IDLE cycle onward.
- cfg_we applies only when FSM=IDLE and start=0. If cfg_we and a legal start coincide, start wins and cfg is dropped.
- mem_ack while no request is outstanding is ignored.

Test Plan:
- PUSH: sp=1000, idx[1]=A55A, no waits, PUSH sel=1 -> writes [0FFF]=A5 then [0FFE]=5A; done 3 cycles after start; sp=0FFE.
- POP with waits: sp=0FFE, memory 0FFE=34, 0FFF=12, ack delayed 2 cycles per access, POP sel=0 -> idx[0]=1234, sp=1000, done 7 cycles after start, mem_addr stable while waiting.
- EX_SP: sp=2000, [2000]=CD, [2001]=AB, idx[0]=1122 -> access order rd 2000, rd 2001, wr 2001=11, wr 2000=22; idx[0]=ABCD; sp=2000.
- Wrap/JP/LD_SP: sp=0000, PUSH idx=BEEF -> writes FFFF=BE, FFFE=EF; then JP sel=0 -> pc_load pulse with pc_val=BEEF; LD_SP -> sp=BEEF, done 1 cycle after start.
- Illegal: op=6 -> err one cycle, no busy. sel=3 with NUM_IDX=2 -> err, no memory access. start while busy -> ignored.
- Reset mid-EX after the first read ack -> next cycle mem_rd=0, sp=FFFF, idx=0, busy=0, no done.

Source files
------------

// File: rtl/xidx_stack_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : xidx_stack_sequencer
// Purpose  : Sequencer for the index-register stack/transfer opcode group
//            (POP xx, PUSH xx, EX (SP),xx, JP (xx), LD SP,xx) over NUM_IDX
//            index registers. Owns SP and the index register file and runs a
//            byte-wide, wait-state tolerant memory handshake.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            start, op, sel        - request from the opcode decoder
//            busy, done, err       - status (busy level, done/err pulses)
//            mem_*                 - byte memory bus (req held until ack)
//            pc_load, pc_val       - PC load pulse and value for JP
//            cfg_we/sp/sel/data    - direct register write while idle
//            sp                    - current stack pointer
//            rd_sel, rd_data       - index register read port
// Revision : 1.0 - initial release
// ============================================================================
module xidx_stack_sequencer #(
    parameter int NUM_IDX = 2,
    parameter int SEL_W   = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [SEL_W-1:0]      sel,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    input  logic                  mem_ack,
    output logic                  pc_load,
    output logic [2*DATA_W-1:0]   pc_val,
    input  logic                  cfg_we,
    input  logic                  cfg_sp,
    input  logic [SEL_W-1:0]      cfg_sel,
    input  logic [2*DATA_W-1:0]   cfg_data,
    output logic [ADDR_W-1:0]     sp,
    input  logic [SEL_W-1:0]      rd_sel,
    output logic [2*DATA_W-1:0]   rd_data
);

    localparam int                c_IDX_W    = 2 * DATA_W;
    localparam logic [2:0]        c_OP_POP   = 3'd0;
    localparam logic [2:0]        c_OP_PUSH  = 3'd1;
    localparam logic [2:0]        c_OP_EX    = 3'd2;
    localparam logic [2:0]        c_OP_JP    = 3'd3;
    localparam logic [2:0]        c_OP_LD_SP = 3'd4;
    localparam logic [1:0]        c_ST_IDLE  = 2'd0;
    localparam logic [1:0]        c_ST_ACC   = 2'd1;
    localparam logic [1:0]        c_ST_FIN   = 2'd2;
    localparam logic [ADDR_W-1:0] c_SP_ONE   = ADDR_W'(1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [1:0]          r_step;
    logic [2:0]          r_op;
    logic [SEL_W-1:0]    r_sel;
    logic [ADDR_W-1:0]   r_sp;
    logic [c_IDX_W-1:0]  r_idx [NUM_IDX];
    logic [DATA_W-1:0]   r_lo;
    logic [DATA_W-1:0]   r_hi;
    logic                r_err;
    logic [c_IDX_W-1:0]  r_pc_val;

    logic                w_sel_ok;
    logic                w_accept;
    logic                w_reject;
    logic                w_cfg_en;
    logic                w_ack;
    logic                w_last_step;
    logic [c_IDX_W-1:0]  w_start_idx;
    logic [c_IDX_W-1:0]  w_cur_idx;
    logic [ADDR_W-1:0]   w_sp_from_idx;
    logic [ADDR_W-1:0]   w_sp_from_cfg;

    // Register selects are compared against each implemented index so that
    // selects >= NUM_IDX simply match nothing.
    always_comb begin
        w_sel_ok    = 1'b0;
        w_start_idx = '0;
        w_cur_idx   = '0;
        rd_data     = '0;
        for (int i = 0; i < NUM_IDX; i++) begin
            if (sel == SEL_W'(i)) begin
                w_sel_ok    = 1'b1;
                w_start_idx = r_idx[i];
            end
            if (r_sel == SEL_W'(i)) begin
                w_cur_idx = r_idx[i];
            end
            if (rd_sel == SEL_W'(i)) begin
                rd_data = r_idx[i];
            end
        end
    end

    assign w_accept    = (r_state == c_ST_IDLE) && start && (op <= c_OP_LD_SP) && w_sel_ok;
    assign w_reject    = (r_state == c_ST_IDLE) && start && !((op <= c_OP_LD_SP) && w_sel_ok);
    // A start (legal or not) takes priority over a direct write in the same cycle.
    assign w_cfg_en    = (r_state == c_ST_IDLE) && !start && cfg_we;
    assign w_ack       = (r_state == c_ST_ACC) && mem_ack;
    assign w_last_step = (r_op == c_OP_EX) ? (r_step == 2'd3) : (r_step == 2'd1);

    // SP loads from a 2*DATA_W source: truncate or zero-extend to ADDR_W.
    generate
        if (ADDR_W <= c_IDX_W) begin : g_sp_trunc
            assign w_sp_from_idx = w_start_idx[ADDR_W-1:0];
            assign w_sp_from_cfg = cfg_data[ADDR_W-1:0];
        end else begin : g_sp_zext
            assign w_sp_from_idx = {{(ADDR_W-c_IDX_W){1'b0}}, w_start_idx};
            assign w_sp_from_cfg = {{(ADDR_W-c_IDX_W){1'b0}}, cfg_data};
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (op <= c_OP_EX) ? c_ST_ACC : c_ST_FIN;
                end
            end
            c_ST_ACC: begin
                if (mem_ack && w_last_step) begin
                    w_state_next = c_ST_FIN;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // Datapath: SP, index registers, captured bytes. Register commits happen
    // on the edge entering FIN so the result is visible during the done cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp     <= '1;
            r_step   <= 2'd0;
            r_op     <= 3'd0;
            r_sel    <= '0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_err    <= 1'b0;
            r_pc_val <= '0;
            for (int i = 0; i < NUM_IDX; i++) begin
                r_idx[i] <= '0;
            end
        end else begin
            r_err <= w_reject;
            if (w_accept) begin
                r_op   <= op;
                r_sel  <= sel;
                r_step <= 2'd0;
                if (op == c_OP_JP) begin
                    r_pc_val <= w_start_idx;
                end
                if (op == c_OP_LD_SP) begin
                    r_sp <= w_sp_from_idx;
                end
            end
            if (w_cfg_en && cfg_sp) begin
                r_sp <= w_sp_from_cfg;
            end
            if (w_ack) begin
                r_step <= r_step + 2'd1;
                case (r_op)
                    c_OP_POP: begin
                        r_sp <= r_sp + c_SP_ONE;
                        if (r_step == 2'd0) begin
                            r_lo <= mem_rdata;
                        end
                    end
                    c_OP_PUSH: begin
                        r_sp <= r_sp - c_SP_ONE;
                    end
                    c_OP_EX: begin
                        if (r_step == 2'd0) begin
                            r_lo <= mem_rdata;
                        end
                        if (r_step == 2'd1) begin
                            r_hi <= mem_rdata;
                        end
                    end
                    default: ;
                endcase
            end
            for (int i = 0; i < NUM_IDX; i++) begin
                if (w_cfg_en && !cfg_sp && (cfg_sel == SEL_W'(i))) begin
                    r_idx[i] <= cfg_data;
                end
                if (w_ack && w_last_step && (r_sel == SEL_W'(i))) begin
                    if (r_op == c_OP_POP) begin
                        r_idx[i] <= {mem_rdata, r_lo};
                    end
                    if (r_op == c_OP_EX) begin
                        r_idx[i] <= {r_hi, r_lo};
                    end
                end
            end
        end
    end

    // Outputs: bus request, address and data are pure functions of the held
    // state and SP, so they stay stable across wait cycles.
    always_comb begin
        busy      = (r_state != c_ST_IDLE);
        done      = (r_state == c_ST_FIN);
        pc_load   = (r_state == c_ST_FIN) && (r_op == c_OP_JP);
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (r_state == c_ST_ACC) begin
            case (r_op)
                c_OP_POP: begin
                    mem_rd   = 1'b1;
                    mem_addr = r_sp;
                end
                c_OP_PUSH: begin
                    mem_wr    = 1'b1;
                    mem_addr  = r_sp - c_SP_ONE;
                    mem_wdata = (r_step == 2'd0) ? w_cur_idx[c_IDX_W-1:DATA_W]
                                                 : w_cur_idx[DATA_W-1:0];
                end
                c_OP_EX: begin
                    case (r_step)
                        2'd0: begin
                            mem_rd   = 1'b1;
                            mem_addr = r_sp;
                        end
                        2'd1: begin
                            mem_rd   = 1'b1;
                            mem_addr = r_sp + c_SP_ONE;
                        end
                        2'd2: begin
                            mem_wr    = 1'b1;
                            mem_addr  = r_sp + c_SP_ONE;
                            mem_wdata = w_cur_idx[c_IDX_W-1:DATA_W];
                        end
                        default: begin
                            mem_wr    = 1'b1;
                            mem_addr  = r_sp;
                            mem_wdata = w_cur_idx[DATA_W-1:0];
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign err    = r_err;
    assign pc_val = r_pc_val;
    assign sp     = r_sp;

endmodule
`default_nettype wire

// File: tb/tb_xidx_stack_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_xidx_stack_sequencer
// Purpose  : Self-checking bench for xidx_stack_sequencer. A byte memory with
//            random wait states answers the bus; a reference model predicts
//            the access list, latency and register results of each opcode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xidx_stack_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [1:0]  sel;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_ack;
    logic        pc_load;
    logic [15:0] pc_val;
    logic        cfg_we;
    logic        cfg_sp;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_data;
    logic [15:0] sp;
    logic [1:0]  rd_sel;
    logic [15:0] rd_data;

    xidx_stack_sequencer #(
        .NUM_IDX (2),
        .SEL_W   (2),
        .ADDR_W  (16),
        .DATA_W  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .sel       (sel),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_ack   (mem_ack),
        .pc_load   (pc_load),
        .pc_val    (pc_val),
        .cfg_we    (cfg_we),
        .cfg_sp    (cfg_sp),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .sp        (sp),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Bench memory and reference architectural state.
    logic [7:0]  mem [65536];
    logic [15:0] m_idx [2];
    logic [15:0] m_sp;
    logic [15:0] m_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] acc(input logic wr, input logic [15:0] a, input logic [7:0] d);
        return {7'd0, wr, a, d};
    endfunction

    task automatic model_reset();
        m_idx[0] = 16'h0000;
        m_idx[1] = 16'h0000;
        m_sp     = 16'hFFFF;
        m_pc     = 16'h0000;
    endtask

    task automatic check_regs(input string tag);
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s);
            #1;
            check({tag, "_rd_data"}, rd_data, (s < 2) ? m_idx[s] : 16'h0000);
        end
        check({tag, "_sp"}, sp, m_sp);
    endtask

    task automatic cfg_write(input logic to_sp, input int s, input logic [15:0] d);
        cfg_we   = 1'b1;
        cfg_sp   = to_sp;
        cfg_sel  = 2'(s);
        cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (to_sp) m_sp = d;
        else if (s < 2) m_idx[s] = d;
    endtask

    // Runs one legal op. wmode<0 gives random waits per access, otherwise a
    // fixed wait count. poke drives start/cfg_we noise while busy; clash
    // drives a direct SP write together with the start.
    task automatic run_op(input logic [2:0] o, input int s, input int wmode,
                          input bit poke, input bit clash);
        logic [31:0] exp_acc[$];
        logic [31:0] got_acc[$];
        logic [31:0] cur;
        logic [15:0] sp0, a1, am1, am2, v, new_idx, new_sp, new_pc;
        int          total_wait, wtarget, wcnt, cyc;
        bit          in_acc, seen_done;

        sp0 = m_sp; v = m_idx[s];
        a1 = sp0 + 16'd1; am1 = sp0 - 16'd1; am2 = sp0 - 16'd2;
        new_idx = v; new_sp = sp0; new_pc = m_pc;
        total_wait = 0; wtarget = 0; wcnt = 0; in_acc = 0; seen_done = 0;
        case (o)
            3'd0: begin
                exp_acc.push_back(acc(1'b0, sp0, 8'h00));
                exp_acc.push_back(acc(1'b0, a1, 8'h00));
                new_idx = {mem[a1], mem[sp0]};
                new_sp  = sp0 + 16'd2;
            end
            3'd1: begin
                exp_acc.push_back(acc(1'b1, am1, v[15:8]));
                exp_acc.push_back(acc(1'b1, am2, v[7:0]));
                new_sp = am2;
            end
            3'd2: begin
                exp_acc.push_back(acc(1'b0, sp0, 8'h00));
                exp_acc.push_back(acc(1'b0, a1, 8'h00));
                exp_acc.push_back(acc(1'b1, a1, v[15:8]));
                exp_acc.push_back(acc(1'b1, sp0, v[7:0]));
                new_idx = {mem[a1], mem[sp0]};
            end
            3'd3: new_pc = v;
            default: new_sp = v;
        endcase

        start = 1'b1; op = o; sel = 2'(s); rd_sel = 2'(s);
        if (clash) begin
            cfg_we = 1'b1; cfg_sp = 1'b1; cfg_data = 16'($urandom);
        end
        @(posedge clk); #1;
        start = 1'b0; cfg_we = 1'b0;
        for (cyc = 1; cyc <= 60 && !seen_done; cyc++) begin
            if (done) begin
                seen_done = 1;
                check("latency", cyc, 1 + exp_acc.size() + total_wait);
                check("busy_at_done", busy, 1'b1);
                check("idx_result", rd_data, new_idx);
                check("sp_result", sp, new_sp);
                check("pc_load", pc_load, (o == 3'd3));
                check("pc_val", pc_val, new_pc);
                mem_ack = 1'b0;
                if (poke) begin
                    start = 1'b1; op = 3'd3; sel = 2'd0;
                    cfg_we = 1'b1; cfg_sp = 1'b1; cfg_data = 16'($urandom);
                end
            end else begin
                check("busy_in_op", busy, 1'b1);
                check("no_err_in_op", err, 1'b0);
                check("no_pc_load_in_op", pc_load, 1'b0);
                if (mem_rd || mem_wr) begin
                    cur = acc(mem_wr, mem_addr, mem_wr ? mem_wdata : 8'h00);
                    if (!in_acc) begin
                        got_acc.push_back(cur);
                        in_acc  = 1;
                        wcnt    = 0;
                        wtarget = (wmode < 0) ? int'($urandom_range(0, 3)) : wmode;
                        total_wait += wtarget;
                    end else begin
                        check("req_stable", cur, got_acc[$]);
                    end
                    check("one_req", mem_rd & mem_wr, 1'b0);
                    mem_rdata = mem[mem_addr];
                    if (wcnt == wtarget) begin
                        mem_ack = 1'b1;
                        in_acc  = 0;
                        if (mem_wr) mem[mem_addr] = mem_wdata;
                    end else begin
                        mem_ack = 1'b0;
                        wcnt++;
                    end
                end else begin
                    mem_ack = 1'b0;
                end
                if (poke) begin
                    start  = 1'b1;
                    op     = cyc[0] ? 3'd7 : 3'd1;
                    sel    = 2'd0;
                    cfg_we = 1'b1; cfg_sp = cyc[1]; cfg_sel = 2'd0;
                    cfg_data = 16'($urandom);
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0; cfg_we = 1'b0; mem_ack = 1'b0;
        check("done_seen", seen_done, 1'b1);
        check("acc_count", got_acc.size(), exp_acc.size());
        for (int k = 0; k < exp_acc.size() && k < got_acc.size(); k++) begin
            check("acc_entry", got_acc[k], exp_acc[k]);
        end
        m_idx[s] = new_idx; m_sp = new_sp; m_pc = new_pc;
        check("busy_after", busy, 1'b0);
        check("done_pulse", done, 1'b0);
        check("err_after", err, 1'b0);
        @(posedge clk); #1;
        check("no_accept_in_done", busy, 1'b0);
        check_regs("post_op");
    endtask

    task automatic illegal(input logic [2:0] o, input int s);
        start = 1'b1; op = o; sel = 2'(s);
        @(posedge clk); #1;
        start = 1'b0;
        check("err_pulse", err, 1'b1);
        check("err_no_busy", busy, 1'b0);
        check("err_no_req", mem_rd | mem_wr, 1'b0);
        @(posedge clk); #1;
        check("err_one_cycle", err, 1'b0);
        check("err_still_idle", busy, 1'b0);
        check_regs("post_err");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; sel = 2'd0; mem_rdata = 8'h00;
        mem_ack = 1'b0; cfg_we = 1'b0; cfg_sp = 1'b0; cfg_sel = 2'd0;
        cfg_data = 16'h0000; rd_sel = 2'd0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_pc_load", pc_load, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_wdata", mem_wdata, 8'h00);
        check("rst_pc_val", pc_val, 16'h0000);
        check_regs("rst");

        // PUSH with no waits
        cfg_write(1'b1, 0, 16'h1000);
        cfg_write(1'b0, 1, 16'hA55A);
        run_op(3'd1, 1, 0, 0, 0);

        // POP with two wait cycles per access
        mem[16'h0FFE] = 8'h34;
        mem[16'h0FFF] = 8'h12;
        run_op(3'd0, 0, 2, 0, 0);

        // EX (SP) with start/cfg noise while busy
        cfg_write(1'b1, 0, 16'h2000);
        cfg_write(1'b0, 0, 16'h1122);
        mem[16'h2000] = 8'hCD;
        mem[16'h2001] = 8'hAB;
        run_op(3'd2, 0, 0, 1, 0);

        // SP wrap, JP, LD SP
        cfg_write(1'b1, 0, 16'h0000);
        cfg_write(1'b0, 0, 16'hBEEF);
        run_op(3'd1, 0, 0, 0, 0);
        run_op(3'd3, 0, 0, 0, 1);
        run_op(3'd4, 0, 0, 0, 0);

        // Illegal op / select
        illegal(3'd6, 0);
        illegal(3'd0, 3);

        // Reset after the first read ack of an EX
        cfg_write(1'b1, 0, 16'h3000);
        cfg_write(1'b0, 0, 16'h5678);
        start = 1'b1; op = 3'd2; sel = 2'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("ex_first_rd", mem_rd, 1'b1);
        mem_rdata = mem[mem_addr];
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        check("abort_mem_rd", mem_rd, 1'b0);
        check("abort_mem_wr", mem_wr, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check_regs("abort");
        @(posedge clk); #1;
        check("abort_no_done", done, 1'b0);

        // Randomised sequence
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                cfg_write(1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 16'($urandom));
            end
            if ($urandom_range(0, 7) == 0) begin
                illegal(3'(5 + $urandom_range(0, 2)), int'($urandom_range(0, 1)));
            end
            run_op(3'($urandom_range(0, 4)), int'($urandom_range(0, 1)), -1,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
